dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_lane_mask.sv | 27 ++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator (master) and the responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_mask.sv
// Byte-enable and lane shift generation from access size and byte lane.
module dmem_lane_mask
    import dmem_pkg::*;
(
    input  size_e             i_size,
    input  logic [2:0]        i_lane,
    output logic [LANE_W-1:0] o_byte_en,
    output logic [5:0]        o_shift
);

    logic [LANE_W-1:0] w_base;

    // Contiguous enable run for the size, moved up to the starting lane.
    always_comb begin
        w_base = '0;
        case (i_size)
            BYTE:   w_base = 8'h01;
            HALF:   w_base = 8'h03;
            WORD:   w_base = 8'h0F;
            DOUBLE: w_base = 8'hFF;
            default: w_base = '0;
        endcase
        o_byte_en = w_base << i_lane;
        o_shift   = {i_lane, 3'b000};
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states, byte-lane
// stores and zero-extended loads. Define DMEM_MISALIGN_ERR_EN to reject
// misaligned accesses; otherwise the address is aligned down to the size.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [63:0]       r_mem [DEPTH_WORDS];
    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_write;
    size_e             r_size;
    logic [63:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_access;
    logic [2:0]        w_align_mask;
    logic [2:0]        w_lane;
    logic              w_misalign;
    logic              w_oor;
    logic              w_err;
    logic [LANE_W-1:0] w_byte_en;
    logic [5:0]        w_shift;
    logic [IDX_W-1:0]  w_idx;
    logic [63:0]       w_bit_mask;
    logic [63:0]       w_rd_word;
    logic [63:0]       w_wr_word;
    logic [63:0]       w_load;

    assign w_align_mask = (3'd1 << r_size) - 3'd1;

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = |(r_addr[2:0] & w_align_mask);
    assign w_lane     = r_addr[2:0];
`else
    assign w_misalign = 1'b0;
    assign w_lane     = r_addr[2:0] & ~w_align_mask;
`endif

    assign w_oor = (r_addr >> (IDX_W + 3)) != '0;
    assign w_err = w_oor | w_misalign;
    assign w_idx = r_addr[IDX_W+2:3];

    dmem_lane_mask u_lane_mask (
        .i_size    (r_size),
        .i_lane    (w_lane),
        .o_byte_en (w_byte_en),
        .o_shift   (w_shift)
    );

    // Expand per-byte enables into a per-bit mask.
    always_comb begin
        w_bit_mask = '0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            w_bit_mask[i*LANE_W +: LANE_W] = {LANE_W{w_byte_en[i]}};
        end
    end

    assign w_rd_word = r_mem[w_idx];
    assign w_wr_word = (w_rd_word & ~w_bit_mask) | ((r_wdata << w_shift) & w_bit_mask);
    assign w_load    = (w_rd_word & w_bit_mask) >> w_shift;

    // Next-state and control; WAIT_CYCLES=0 still passes through one WAIT
    // cycle so accept-to-response latency is uniformly WAIT_CYCLES+1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_size  <= BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_size  <= size_e'(bus.req_size);
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? '0 : w_load;
            end
        end
    end

    // Storage write, committed on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (w_access && r_write && !w_err) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign bus.req_ready = (r_state == IDLE) && reset_n;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule
